// File: rtl/prompt_sequencer_pkg.sv
// Shared definitions for the prompt sequencer: button codes, click masks,
// sequencer state encoding and the LFSR step rule.
package prompt_sequencer_pkg;

    localparam int unsigned CODE_W  = 3;
    localparam int unsigned MASK_W  = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [CODE_W-1:0] BTN_A     = 3'd1;
    localparam logic [CODE_W-1:0] BTN_B     = 3'd2;
    localparam logic [CODE_W-1:0] BTN_SEL   = 3'd3;
    localparam logic [CODE_W-1:0] BTN_UP    = 3'd4;
    localparam logic [CODE_W-1:0] BTN_DOWN  = 3'd5;
    localparam logic [CODE_W-1:0] BTN_LEFT  = 3'd6;
    localparam logic [CODE_W-1:0] BTN_RIGHT = 3'd7;

    localparam logic [MASK_W-1:0] MASK_A     = 8'h01;
    localparam logic [MASK_W-1:0] MASK_B     = 8'h02;
    localparam logic [MASK_W-1:0] MASK_SEL   = 8'h04;
    localparam logic [MASK_W-1:0] MASK_STAR  = 8'h08;
    localparam logic [MASK_W-1:0] MASK_UP    = 8'h10;
    localparam logic [MASK_W-1:0] MASK_DOWN  = 8'h20;
    localparam logic [MASK_W-1:0] MASK_LEFT  = 8'h40;
    localparam logic [MASK_W-1:0] MASK_RIGHT = 8'h80;

    typedef logic [STATE_W-1:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 3'd0;
    localparam seq_state_t ST_ISSUE     = 3'd1;
    localparam seq_state_t ST_WAIT_DONE = 3'd2;
    localparam seq_state_t ST_EVAL      = 3'd3;
    localparam seq_state_t ST_RELEASE   = 3'd4;
    localparam seq_state_t ST_GAP       = 3'd5;
    localparam seq_state_t ST_OVER      = 3'd6;

    // Click mask a checker expects for a given prompt code (star has no code).
    function automatic logic [MASK_W-1:0] code_to_mask(input logic [CODE_W-1:0] code);
        logic [MASK_W-1:0] m;
        m = '0;
        case (code)
            BTN_A:     m = MASK_A;
            BTN_B:     m = MASK_B;
            BTN_SEL:   m = MASK_SEL;
            BTN_UP:    m = MASK_UP;
            BTN_DOWN:  m = MASK_DOWN;
            BTN_LEFT:  m = MASK_LEFT;
            BTN_RIGHT: m = MASK_RIGHT;
            default:   m = '0;
        endcase
        return m;
    endfunction

    // 8-bit right-shifting Galois LFSR, taps 0xB8.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

endpackage

// File: rtl/prompt_sequencer_lfsr.sv
// Prompt pseudo-random source: seed on reset, advance one step when asked.
module prompt_lfsr
    import prompt_sequencer_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/prompt_sequencer.sv
// Game-side initiator for the button-check handshake: issues prompts, scores
// rounds from the checker's correct count, paces and ends the game.
// Optional feature macro: PROMPT_SPEEDUP_EN (shrinking response window).
module prompt_sequencer
    import prompt_sequencer_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES    = 12_500_000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5,
    parameter int unsigned MAX_MISSES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       chk_done,
    input  logic [7:0] chk_correct,
    output logic       chk_en,
    output logic [2:0] val,
    output logic [7:0] round,
    output logic [7:0] score,
    output logic [1:0] misses,
    output logic       game_over,
    output logic       timed_out
);

    localparam int unsigned TW         = 32;
    localparam logic [TW-1:0] WIN      = TW'(WINDOW_CYCLES);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [1:0] MISS_LIMIT  = 2'(MAX_MISSES);

    seq_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] win_cur;
    logic [7:0]    prev_q, prev_d;
    logic [7:0]    lfsr;
    logic          lfsr_step;
    logic          game_start;
    logic [2:0]    val_d;
    logic [7:0]    round_d, score_d;
    logic [1:0]    misses_d;
    logic          timed_out_d;

    prompt_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr)
    );

`ifdef PROMPT_SPEEDUP_EN
    localparam logic [TW-1:0] WIN_STEP  = WIN >> 4;
    localparam logic [TW-1:0] WIN_FLOOR = WIN >> 2;

    logic [TW-1:0] window_q, window_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= WIN;
        end else begin
            window_q <= window_d;
        end
    end

    assign win_cur = window_q;
`else
    assign win_cur = WIN;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        prev_d      = prev_q;
        val_d       = val;
        round_d     = round;
        score_d     = score;
        misses_d    = misses;
        timed_out_d = timed_out;
        lfsr_step   = 1'b0;
        game_start  = 1'b0;
`ifdef PROMPT_SPEEDUP_EN
        window_d    = window_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    game_start = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lfsr_step = 1'b1;
                prev_d    = chk_correct;
                timer_d   = win_cur - TW'(1);
                state_d   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the expiry cycle still counts as an answer.
                if (chk_done) begin
                    state_d = ST_EVAL;
                end else if (timer_q == '0) begin
                    timed_out_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_EVAL: begin
                if (chk_correct != prev_q) begin
                    score_d = (score == 8'hFF) ? score : score + 8'd1;
`ifdef PROMPT_SPEEDUP_EN
                    window_d = (window_q >= WIN_FLOOR + WIN_STEP) ? window_q - WIN_STEP
                                                                  : WIN_FLOOR;
`endif
                end else begin
                    misses_d = (misses == MISS_LIMIT) ? misses : misses + 2'd1;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!chk_done) begin
                    timer_d = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    if (misses == MISS_LIMIT || round == 8'hFF) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_OVER: begin
                if (start) begin
                    game_start = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (game_start) begin
            round_d     = '0;
            score_d     = '0;
            misses_d    = '0;
            timed_out_d = 1'b0;
`ifdef PROMPT_SPEEDUP_EN
            window_d    = WIN;
`endif
        end

        // Prompt is latched on the edge entering ISSUE so it leads chk_en by a cycle.
        if (state_d == ST_ISSUE) begin
            val_d   = (lfsr[2:0] == 3'd0) ? BTN_A : lfsr[2:0];
            round_d = (round_d == 8'hFF) ? round_d : round_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            prev_q    <= '0;
            chk_en    <= 1'b0;
            val       <= '0;
            round     <= '0;
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            prev_q    <= prev_d;
            chk_en    <= (state_d == ST_WAIT_DONE);
            val       <= val_d;
            round     <= round_d;
            score     <= score_d;
            misses    <= misses_d;
            game_over <= (state_d == ST_OVER);
            timed_out <= timed_out_d;
        end
    end

    // The Galois LFSR locks up at zero; a nonzero seed keeps it off that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (lfsr != 8'h00);
        end
    end

endmodule

// File: tb/tb_prompt_sequencer.sv
// Self-checking bench for prompt_sequencer: a vector table of scripted rounds,
// hand-written restart/timeout/reset sequences, then randomized games.
module tb_prompt_sequencer;

    localparam int unsigned W    = 20;
    localparam int unsigned G    = 4;
    localparam int unsigned MAXM = 3;
    localparam logic [7:0]  SEED = 8'hA5;
    localparam int          LIM  = 200;

    logic       clk;
    logic       rst;
    logic       start;
    logic       chk_done;
    logic [7:0] chk_correct;
    logic       chk_en;
    logic [2:0] val;
    logic [7:0] round;
    logic [7:0] score;
    logic [1:0] misses;
    logic       game_over;
    logic       timed_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cnt;
    logic [7:0] m_lfsr;
    int m_round, m_score, m_misses, m_window;

    typedef struct {
        int         d;       // 0 = never answer, -1 = answer on the last window cycle
        bit         good;
        logic [2:0] ev;
        logic [7:0] es;
        logic [1:0] em;
        bit         eover;
    } vec_t;

    vec_t tbl [5];

    prompt_sequencer #(
        .WINDOW_CYCLES (W),
        .GAP_CYCLES    (G),
        .LFSR_SEED     (SEED),
        .MAX_MISSES    (MAXM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .chk_done    (chk_done),
        .chk_correct (chk_correct),
        .chk_en      (chk_en),
        .val         (val),
        .round       (round),
        .score       (score),
        .misses      (misses),
        .game_over   (game_over),
        .timed_out   (timed_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Reference for one round: what the prompt, counters and end-of-game must be.
    task automatic model_round(input int d, input bit good,
                               output logic [2:0] ev, output logic [7:0] er,
                               output logic [7:0] es, output logic [1:0] em,
                               output bit eover, output int win);
        ev     = (m_lfsr[2:0] == 3'd0) ? 3'd1 : m_lfsr[2:0];
        m_lfsr = ref_step(m_lfsr);
        if (m_round < 255) m_round++;
        win = m_window;
        if (d == 0) begin
            eover = 1'b1;
        end else begin
            if (good) begin
                if (m_score < 255) m_score++;
`ifdef PROMPT_SPEEDUP_EN
                m_window = m_window - int'(W / 16);
                if (m_window < int'(W / 4)) m_window = int'(W / 4);
`endif
            end else if (m_misses < int'(MAXM)) begin
                m_misses++;
            end
            eover = (m_misses == int'(MAXM)) || (m_round == 255);
        end
        er = 8'(m_round);
        es = 8'(m_score);
        em = 2'(m_misses);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_round  = 0;
        m_score  = 0;
        m_misses = 0;
        m_window = int'(W);
        check("start_round", round, 1);
        check("start_score", score, 0);
        check("start_misses", misses, 0);
        check("start_timed_out", timed_out, 0);
        check("start_game_over", game_over, 0);
    endtask

    // Entered on the ISSUE cycle; leaves on the first cycle of ISSUE or OVER.
    task automatic run_round(input int d, input bit good, input logic [2:0] ev,
                             input logic [7:0] er, input logic [7:0] es,
                             input logic [1:0] em, input bit eover, input int win);
        int n;
        int k;
        logic [2:0] pv;
        n  = 0;
        pv = val;
        while (chk_en !== 1'b1 && n < LIM) begin
            pv = val;
            tick();
            n++;
        end
        check("en_rise_delay", n, 1);
        check("val_before_en", pv, ev);
        check("val", val, ev);
        check("round", round, er);
        if (d == 0) begin
            k = 0;
            while (chk_en === 1'b1 && k < LIM) begin
                tick();
                k++;
            end
            check("window_len", k, win);
            check("timeout_game_over", game_over, 1);
            check("timeout_flag", timed_out, 1);
        end else begin
            repeat (d - 1) tick();
            check("en_hold", chk_en, 1);
            chk_done = 1'b1;
            if (good) cnt = cnt + 8'd1;
            chk_correct = cnt;
            tick();
            check("en_drop", chk_en, 0);
            repeat ($urandom_range(1, 3)) tick();
            chk_done = 1'b0;
            check("score", score, es);
            check("misses", misses, em);
            check("val_stable", val, ev);
            repeat (G) tick();
            check("gap_idle", {game_over, chk_en}, 0);
            tick();
            check("end_game_over", game_over, eover);
            check("end_timed_out", timed_out, 0);
        end
    endtask

    initial begin
        logic [2:0] mv;
        logic [7:0] mr, ms;
        logic [1:0] mm;
        bit mo;
        int win;
        int d;
        bit good;
        int n;
        int guard;

        tbl[0] = '{3,  1'b1, 3'd5, 8'd1, 2'd0, 1'b0};
        tbl[1] = '{1,  1'b0, 3'd2, 8'd1, 2'd1, 1'b0};
        tbl[2] = '{-1, 1'b1, 3'd5, 8'd2, 2'd1, 1'b0};
        tbl[3] = '{7,  1'b0, 3'd2, 8'd2, 2'd2, 1'b0};
        tbl[4] = '{-1, 1'b0, 3'd1, 8'd2, 2'd3, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        chk_done = 1'b0;
        cnt = 8'd0;
        chk_correct = cnt;
        m_lfsr = SEED;
        m_round = 0;
        m_score = 0;
        m_misses = 0;
        m_window = int'(W);

        repeat (3) tick();
        check("reset_outputs", {chk_en, val, round, score, misses, game_over, timed_out}, 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_outputs", {chk_en, val, round, score, misses, game_over, timed_out}, 0);

        // Scripted game: correct, misses, answers on the expiry cycle, miss limit.
        do_start();
        for (int i = 0; i < 5; i++) begin
            model_round(tbl[i].d, tbl[i].good, mv, mr, ms, mm, mo, win);
            d = (tbl[i].d < 0) ? win : tbl[i].d;
            run_round(d, tbl[i].good, tbl[i].ev, 8'(i + 1), tbl[i].es, tbl[i].em,
                      tbl[i].eover, win);
        end

        // Restart from OVER without reseeding, then let the window run out.
        do_start();
        model_round(0, 1'b0, mv, mr, ms, mm, mo, win);
        check("restart_val_continues", mv, 1);
        run_round(0, 1'b0, mv, mr, ms, mm, mo, win);

        // Restart clears timed_out; reset mid-round returns everything to zero.
        do_start();
        n = 0;
        while (chk_en !== 1'b1 && n < LIM) begin
            tick();
            n++;
        end
        check("pre_reset_en", chk_en, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midround_reset", {chk_en, val, round, score, misses, game_over, timed_out}, 0);
        rst = 1'b0;
        tick();
        tick();
        check("post_reset_idle", {chk_en, game_over, round}, 0);
        m_lfsr = SEED;

        // Randomized games against the reference model.
        for (int g = 0; g < 4; g++) begin
            do_start();
            mo = 1'b0;
            guard = 0;
            while (!mo && guard < 300) begin
                if ($urandom_range(0, 11) == 0) d = 0;
                else if ($urandom_range(0, 5) == 0) d = -1;
                else d = 1;
                good = ($urandom_range(0, 2) != 0);
                model_round(d, good, mv, mr, ms, mm, mo, win);
                if (d < 0) d = win;
                else if (d > 0) d = $urandom_range(1, win);
                run_round(d, good, mv, mr, ms, mm, mo, win);
                guard++;
            end
        end

        // Full-length game: the round counter limit ends it.
        do_start();
        for (int r = 0; r < 255; r++) begin
            model_round(1, 1'b1, mv, mr, ms, mm, mo, win);
            run_round(1, 1'b1, mv, mr, ms, mm, mo, win);
        end
        tick();
        check("final_round", round, 255);
        check("final_score", score, 255);
        check("final_over", game_over, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prompt_sequencer.md
# prompt_sequencer

Game-side initiator for the button-check handshake. It issues a pseudo-random 3-bit button code to `ButtonCheck`, holds `en` until the checker reports `done`, and scores the round from the change in the checker's `correct` count. It then paces the next prompt and ends the game on a miss limit or a response timeout. It sits between the top-level game controller (start button, score/round displays) and `ButtonCheck`.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 50_000_000: response window per prompt, in clock cycles.
- `GAP_CYCLES`, default 12_500_000: idle gap between the checker releasing and the next prompt.
- `LFSR_SEED`, default 8'hA5: LFSR value loaded on reset; must be nonzero.
- `MAX_MISSES`, default 3: wrong answers allowed before game over; range 1..3.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: level. Begins a game from IDLE; restarts from OVER.
- `chk_done`, in, 1: `done` from the checker.
- `chk_correct`, in, 8: `correct` count from the checker.
- `chk_en`, out, 1: drives checker `en`.
- `val`, out, 3: expected button code.
  - 1 = a, 2 = b, 3 = sel, 4 = up, 5 = down, 6 = left, 7 = right.
- `round`, out, 8: prompts issued this game.
- `score`, out, 8: rounds answered correctly.
- `misses`, out, 2: wrong answers this game.
- `game_over`, out, 1: high while in OVER.
- `timed_out`, out, 1: set when the game ended by timeout; cleared on the next game start.

## Operation
- Reset values: every output 0, LFSR = `LFSR_SEED`, FSM in IDLE.
- States:
  - IDLE: wait for `start`=1, then go to ISSUE.
  - ISSUE (1 cycle):
    - Latch `val` = LFSR[2:0]; if LFSR[2:0] is 0, use 3'd1.
    - Step the LFSR once.
    - Capture `prev_correct` = `chk_correct`.
    - `round` += 1.
    - Load the window timer. Go to WAIT_DONE.
  - WAIT_DONE:
    - `chk_en`=1.
    - If `chk_done`=1, go to EVAL.
    - Otherwise, if the timer reaches 0, set `timed_out` and go to OVER.
  - EVAL (1 cycle):
    - If `chk_correct` != `prev_correct`, `score` += 1.
    - Otherwise `misses` += 1.
    - Go to RELEASE.
  - RELEASE:
    - `chk_en`=0.
    - Wait for `chk_done`=0, then load the gap timer and go to GAP.
  - GAP:
    - When the timer reaches 0: go to OVER if `misses`==`MAX_MISSES` or `round`==255; otherwise go to ISSUE.
  - OVER:
    - `game_over`=1 and `chk_en`=0.
    - `start`=1 clears `round`, `score`, `misses` and `timed_out`, then goes to ISSUE.
    - The LFSR is not reseeded.
- LFSR: 8-bit Galois, right shift. If bit 0 = 1: next = (lfsr>>1)^8'hB8; otherwise next = lfsr>>1. It steps only in ISSUE, so the prompt sequence is deterministic.
- `val` stays stable from ISSUE until the next ISSUE.
- `score` and `round` saturate at 255. `misses` never exceeds `MAX_MISSES`.
- Timeout path: `chk_en` drops while the checker may still be waiting for a click. The top level must reset the checker before restart.

## Timing
- All outputs are registered.
- `chk_en` rises on the edge entering WAIT_DONE, so `val` has been valid for at least 1 cycle before it.
- `chk_done` is sampled every cycle in WAIT_DONE. The checker's `correct` is already updated when `done` rises, so a single-cycle EVAL compare is valid.
- Minimum round length: ISSUE(1) + WAIT_DONE(≥1) + EVAL(1) + RELEASE(≥1) + `GAP_CYCLES`.
- Timer: loaded with N and counts down to 0, giving exactly N cycles before expiry.
- `chk_done` and timer expiry in the same cycle: `chk_done` wins (go to EVAL).
- `rst` has priority over everything, mid-round included. It returns all outputs to their reset values in the next cycle.

## Configuration
- `PROMPT_SPEEDUP_EN`:
  - When defined, each correct EVAL reduces the window reload by `WINDOW_CYCLES`/16, floored at `WINDOW_CYCLES`/4. A new game restores `WINDOW_CYCLES`.
  - When undefined, every prompt uses `WINDOW_CYCLES`.

## Structure
- Shared package holds:
  - the 3-bit button code constants (1..7);
  - the matching 8-bit one-hot click masks (a=bit0, b=bit1, sel=bit2, star=bit3, up=bit4, down=bit5, left=bit6, right=bit7);
  - the sequencer state enum.
- One sub-module, `prompt_lfsr`: seed load, step enable, 8-bit state out.

## Test plan
- Reset, then `start`: first `val`=5, `round`=1, `chk_en`=1. After the next round's gap, `val`=2 (LFSR A5 → EA).
- Checker model raises `correct` 0→1 with `done`: `score`=1, `misses`=0, `chk_en` drops. The next ISSUE waits until `done`=0 plus `GAP_CYCLES`.
- Three prompts answered with `correct` unchanged (`MAX_MISSES`=3): `misses`=3, then `game_over`=1, `timed_out`=0.
- No `done` for `WINDOW_CYCLES` (set to 20): `timed_out`=1 and `game_over`=1 on cycle 20 of WAIT_DONE.
- `done` and timer expiry in the same cycle: scored normally, `timed_out`=0.
- `PROMPT_SPEEDUP_EN`, `WINDOW_CYCLES`=64: window is 60, 56, ... after correct rounds, floored at 16.
